// File: rtl/bbox_accumulator.sv
// rtl/bbox_accumulator.sv - per-label bounding-box accumulator with label-merge resolution
// Collects boxes over a frame, resolves merged labels to roots, then streams descriptors max label down to 1.
module bbox_accumulator #(
  parameter int WIDTH_BITS  = 11,
  parameter int HEIGHT_BITS = 10,
  parameter int LABEL_WIDTH = 8,
  parameter int NUM_LABELS  = 1 << LABEL_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_enable,
  input  logic                   i_pixel_valid_in,
  input  logic [LABEL_WIDTH-1:0] i_pixel_label,
  input  logic                   i_last_in_frame,
  input  logic                   i_merge_valid,
  input  logic [LABEL_WIDTH-1:0] i_merge_hi,
  input  logic [LABEL_WIDTH-1:0] i_merge_lo,
  input  logic [WIDTH_BITS-1:0]  i_width,
  input  logic [HEIGHT_BITS-1:0] i_height,
  output logic                   o_frame_done,
  output logic                   o_bbox_valid,
  output logic [LABEL_WIDTH-1:0] o_bbox_label,
  output logic [LABEL_WIDTH-1:0] o_bbox_parent,
  output logic [WIDTH_BITS-1:0]  o_bbox_min_x,
  output logic [HEIGHT_BITS-1:0] o_bbox_min_y,
  output logic [WIDTH_BITS-1:0]  o_bbox_max_x,
  output logic [HEIGHT_BITS-1:0] o_bbox_max_y,
  output logic                   o_busy,
  output logic                   o_dropped
);
  typedef logic [LABEL_WIDTH-1:0] label_t;
  typedef enum logic [1:0] {S_ACCUM, S_RESOLVE, S_DONE, S_EMIT} state_t;

  state_t                 r_state, w_state_next;
  logic [WIDTH_BITS-1:0]  r_x;
  logic [HEIGHT_BITS-1:0] r_y;
  label_t                 r_max_label;
  logic [LABEL_WIDTH:0]   r_r;
  label_t                 r_e;

  logic [WIDTH_BITS-1:0]  r_min_x [NUM_LABELS];
  logic [HEIGHT_BITS-1:0] r_min_y [NUM_LABELS];
  logic [WIDTH_BITS-1:0]  r_max_x [NUM_LABELS];
  logic [HEIGHT_BITS-1:0] r_max_y [NUM_LABELS];
  logic                   r_seen  [NUM_LABELS];
  label_t                 r_parent[NUM_LABELS];

  logic   w_pix_acc, w_pix_hit, w_merge_acc;
  label_t w_max_next, w_p, w_mrg_idx, w_mrg_val;
  label_t w_res_idx, w_res_val, w_e_first, w_emit_idx;
  logic   w_emit_load, w_emit_last;
  logic   w_unused_height;

  assign w_unused_height = ^i_height;

  assign w_pix_acc   = i_pixel_valid_in && (r_state == S_ACCUM);
  assign w_pix_hit   = w_pix_acc && (i_pixel_label != '0);
  assign w_merge_acc = i_merge_valid && (r_state == S_ACCUM);
  assign w_max_next  = (w_pix_hit && (i_pixel_label > r_max_label)) ? i_pixel_label : r_max_label;

  // Parent pointers always point downward, so one hop through an already-resolved
  // lower label lands on the root.
  assign w_p       = r_parent[i_merge_hi];
  assign w_res_idx = r_r[LABEL_WIDTH-1:0];
  assign w_res_val = r_parent[r_parent[w_res_idx]];

  assign w_e_first   = (r_max_label > label_t'(1)) ? r_max_label : label_t'(1);
  assign w_emit_idx  = (r_state == S_DONE) ? w_e_first : (r_e - label_t'(1));
  assign w_emit_load = (r_state == S_DONE) || ((r_state == S_EMIT) && (r_e != label_t'(1)));
  assign w_emit_last = (r_state == S_EMIT) && (r_e == label_t'(1));

  assign o_frame_done = (r_state == S_DONE);
  assign o_busy       = (r_state != S_ACCUM);

  always_comb begin
    w_mrg_idx = i_merge_hi;
    w_mrg_val = i_merge_lo;
    if (w_p != i_merge_hi) begin
      w_mrg_idx = (w_p > i_merge_lo) ? w_p : i_merge_lo;
      w_mrg_val = (w_p > i_merge_lo) ? i_merge_lo : w_p;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_ACCUM:
        if (w_pix_acc && i_last_in_frame)
          w_state_next = (w_max_next > label_t'(1)) ? S_RESOLVE : S_DONE;
      S_RESOLVE:
        if (r_r >= {1'b0, r_max_label}) w_state_next = S_DONE;
      S_DONE:
        w_state_next = S_EMIT;
      S_EMIT:
        if (r_e == label_t'(1)) w_state_next = S_ACCUM;
      default:
        w_state_next = S_ACCUM;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_ACCUM;
    end else if (i_enable) begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x           <= '0;
      r_y           <= '0;
      r_max_label   <= '0;
      r_r           <= '0;
      r_e           <= '0;
      o_dropped     <= 1'b0;
      o_bbox_valid  <= 1'b0;
      o_bbox_label  <= '0;
      o_bbox_parent <= '0;
      o_bbox_min_x  <= '0;
      o_bbox_min_y  <= '0;
      o_bbox_max_x  <= '0;
      o_bbox_max_y  <= '0;
    end else if (i_enable) begin
      if ((r_state != S_ACCUM) && (i_pixel_valid_in || i_merge_valid)) o_dropped <= 1'b1;
      if (w_pix_acc) begin
        r_max_label <= w_max_next;
        if (i_last_in_frame) begin
          r_x <= '0;
          r_y <= '0;
          r_r <= (LABEL_WIDTH+1)'(2);
        end else if (r_x == i_width - WIDTH_BITS'(1)) begin
          r_x <= '0;
          r_y <= r_y + HEIGHT_BITS'(1);
        end else begin
          r_x <= r_x + WIDTH_BITS'(1);
        end
      end
      if (r_state == S_RESOLVE) r_r <= r_r + (LABEL_WIDTH+1)'(1);
      if (w_emit_load) begin
        r_e           <= w_emit_idx;
        o_bbox_valid  <= r_seen[w_emit_idx];
        o_bbox_label  <= w_emit_idx;
        o_bbox_parent <= r_parent[w_emit_idx];
        o_bbox_min_x  <= r_min_x[w_emit_idx];
        o_bbox_min_y  <= r_min_y[w_emit_idx];
        o_bbox_max_x  <= r_max_x[w_emit_idx];
        o_bbox_max_y  <= r_max_y[w_emit_idx];
      end
      if (w_emit_last) begin
        r_max_label  <= '0;
        o_bbox_valid <= 1'b0;
      end
    end
  end

  // Each entry is wiped as it is emitted, leaving the table clean for the next frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_LABELS; i++) begin
        r_min_x[i]  <= '1;
        r_min_y[i]  <= '1;
        r_max_x[i]  <= '0;
        r_max_y[i]  <= '0;
        r_seen[i]   <= 1'b0;
        r_parent[i] <= label_t'(i);
      end
    end else if (i_enable) begin
      if (w_pix_hit) begin
        if (r_x < r_min_x[i_pixel_label]) r_min_x[i_pixel_label] <= r_x;
        if (r_y < r_min_y[i_pixel_label]) r_min_y[i_pixel_label] <= r_y;
        if (r_x > r_max_x[i_pixel_label]) r_max_x[i_pixel_label] <= r_x;
        if (r_y > r_max_y[i_pixel_label]) r_max_y[i_pixel_label] <= r_y;
        r_seen[i_pixel_label] <= 1'b1;
      end
      if (w_merge_acc) r_parent[w_mrg_idx] <= w_mrg_val;
      if (r_state == S_RESOLVE) r_parent[w_res_idx] <= w_res_val;
      if (w_emit_load) begin
        r_min_x[w_emit_idx]  <= '1;
        r_min_y[w_emit_idx]  <= '1;
        r_max_x[w_emit_idx]  <= '0;
        r_max_y[w_emit_idx]  <= '0;
        r_seen[w_emit_idx]   <= 1'b0;
        r_parent[w_emit_idx] <= w_emit_idx;
      end
    end
  end
endmodule
